stage_sequencer: RTL and testbench
==================================

Name: stage_sequencer

Overview:
Parametrised multi-cycle control sequencer, the successor to the fixed 5-stage one-hot control unit. It drives the one-hot `stage` vector consumed by the datapath (data_memory_top, stage5_top). Per instruction, stages can be skipped via a mask latched at decode, and any stage can stretch over several cycles via a ready handshake. It adds a stall watchdog, a graceful halt at instruction boundaries and a retired-instruction counter.

Parameters:
NUM_STAGES, 5, number of stages; one-hot width; index 0 = fetch
DECODE_STAGE, 1, index of the decode stage; skip_mask is sampled when leaving it
MAX_WAIT, 15, max stall cycles tolerated in one stage; 0 disables the watchdog
CNT_W, 32, width of the retired counter

Ports:
clock  in  1  system clock; all state updates on rising edge
reset  in  1  synchronous, active-low reset
stage_ready  in  NUM_STAGES  bit i high = stage i finished this cycle
skip_mask  in  NUM_STAGES  stages to skip for the current instruction; valid during DECODE_STAGE
halt_req  in  1  request to stop after the current instruction
stage  out  NUM_STAGES  one-hot active stage; all-zero when HALTED or FAULT
stage_index  out  clog2(NUM_STAGES)  binary index of the active stage; 0 when HALTED or FAULT
instr_done  out  1  one-cycle pulse after an instruction completes
retired  out  CNT_W  completed-instruction count; wraps modulo 2^CNT_W
wait_count  out  clog2(MAX_WAIT+1)  stall cycles spent in the current stage
halted  out  1  sticky; set on halt
fault  out  1  sticky; set on watchdog timeout

Behaviour:
- Reset (reset==0 at an edge, regardless of state): stage=1 (bit 0 set), stage_index=0, retired=0, wait_count=0, instr_done=0, halted=0, fault=0, skip latch=0, halt pending=0, state=RUN.
- States:
  - RUN: normal sequencing.
  - HALTED: stage all-zero, halted=1.
  - FAULT: stage all-zero, fault=1.
  - HALTED and FAULT are exited only by reset. All inputs are ignored there, except that wait_count holds 0.
- Active mask:
  - active = ~skip_latched, with bits 0 and DECODE_STAGE forced to 1.
  - On the edge leaving DECODE_STAGE, the next-stage search uses the incoming skip_mask directly, and skip_latched loads skip_mask on the same edge.
- Advance: in RUN, if stage_ready[stage_index]==1, the next edge moves to the lowest active index j > stage_index. Bits of stage_ready for inactive stages are ignored.
- Completion: if no active j exists, the instruction completes.
  - Next state is stage 0, or HALTED if halt is pending.
  - retired increments on that edge.
  - instr_done is high for exactly the following cycle.
  - skip_latched clears to 0.
- Latency: with all stages ready and none skipped, an instruction takes NUM_STAGES cycles. Each skipped stage removes one cycle; each stall cycle adds one.
- Wait counter:
  - Clears on every stage change.
  - Otherwise increments each RUN cycle in which the current stage is not ready.
  - If MAX_WAIT>0, wait_count==MAX_WAIT and the stage is not ready, the next edge enters FAULT.
- Halt:
  - A halt_req sample of 1 in any RUN cycle sets halt pending.
  - Pending is acted on at the next completion edge; the completing instruction still retires and still pulses instr_done.
- Simultaneous events:
  - Fault and completion cannot coincide, because completion requires ready.
  - halt_req in the completing cycle itself counts; the sequencer halts at that boundary.
  - Pending halt plus fault: fault wins, halted stays 0.
- Reset mid-operation (any stage, any wait_count) aborts the instruction; retired does not increment.

Decomposition:
- Shared package (definitions.vh): stage-index constants (`fetch_stage`, `decode_stage`, `alu_stage`, `data_stage`, `reg_stage`) and the sequencer state enum typedef (RUN/HALTED/FAULT).
- One natural combinational sub-module, `next_stage_finder`: given the current index and the active mask, it returns the next index and a wrap flag via a priority search.

Test Plan:
1. NUM_STAGES=5, stage_ready=5'b11111, skip_mask=0 -> stage 00001,00010,00100,01000,10000,00001; instr_done high in cycle 6 only; retired=1.
2. skip_mask=5'b01000 during decode -> stage 00001,00010,00100,10000,00001 (4 cycles); next instruction with skip_mask=0 takes 5 cycles. Check that skip_mask bits 0/1 set are ignored.
3. stage_ready[2]=0 for 3 cycles, then 1 -> stage 00100 held 4 cycles, wait_count 0,1,2,3, then 0 on advance; instruction takes 8 cycles.
4. MAX_WAIT=4, stage_ready[3] held 0 -> wait_count reaches 4. On the 6th cycle after entering stage 3: fault=1, stage=0, retired unchanged; later ready pulses have no effect.
5. halt_req pulsed for one cycle in stage 2 -> instruction finishes, retired+1, instr_done pulses, halted=1, stage=0. One cycle of reset=0 then returns stage=00001, halted=0.
6. reset=0 in stage 3 with wait_count=2 -> next edge: stage=00001, wait_count=0, retired unchanged from before (not incremented), instr_done=0; MAX_WAIT=0 with a 40-cycle stall -> no fault.

Source files
------------

// File: rtl/stage_sequencer_pkg.sv
// Shared definitions for the stage sequencer: stage indices, sequencer state
// encoding and a width helper used for index/counter ports.
package stage_sequencer_pkg;

  localparam int fetch_stage  = 0;
  localparam int decode_stage = 1;
  localparam int alu_stage    = 2;
  localparam int data_stage   = 3;
  localparam int reg_stage    = 4;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    HALTED = 2'd1,
    FAULT  = 2'd2
  } seq_state_e;

  // Minimum of one bit so degenerate parameter choices still elaborate.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/stage_sequencer_next_stage_finder.sv
// Priority search for the lowest active stage above the current one; wrap_o
// flags that none exists and the instruction is complete.
module next_stage_finder
  import stage_sequencer_pkg::*;
#(
  parameter int NUM_STAGES = 5,
  parameter int IDX_W      = idx_width(NUM_STAGES)
) (
  input  logic [IDX_W-1:0]      cur_idx_i,
  input  logic [NUM_STAGES-1:0] active_i,
  output logic [IDX_W-1:0]      next_idx_o,
  output logic                  wrap_o
);

  // Descending scan so the last hit, i.e. the lowest qualifying index, wins.
  always_comb begin
    next_idx_o = '0;
    wrap_o     = 1'b1;
    for (int j = NUM_STAGES - 1; j >= 0; j--) begin
      if ((j > int'(cur_idx_i)) && active_i[j]) begin
        next_idx_o = IDX_W'(j);
        wrap_o     = 1'b0;
      end
    end
  end

endmodule

// File: rtl/stage_sequencer.sv
// One-hot multi-cycle stage sequencer with per-instruction skip mask, ready
// handshake, stall watchdog, graceful halt and retired-instruction counter.
module stage_sequencer
  import stage_sequencer_pkg::*;
#(
  parameter int NUM_STAGES   = 5,
  parameter int DECODE_STAGE = decode_stage,
  parameter int MAX_WAIT     = 15,
  parameter int CNT_W        = 32
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic [NUM_STAGES-1:0]                stage_ready,
  input  logic [NUM_STAGES-1:0]                skip_mask,
  input  logic                                 halt_req,
  output logic [NUM_STAGES-1:0]                stage,
  output logic [idx_width(NUM_STAGES)-1:0]     stage_index,
  output logic                                 instr_done,
  output logic [CNT_W-1:0]                     retired,
  output logic [idx_width(MAX_WAIT+1)-1:0]     wait_count,
  output logic                                 halted,
  output logic                                 fault
);

  localparam int IDX_W  = idx_width(NUM_STAGES);
  localparam int WAIT_W = idx_width(MAX_WAIT + 1);

  seq_state_e             state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [CNT_W-1:0]       retired_q, retired_d;
  logic [WAIT_W-1:0]      wait_q, wait_d;
  logic [NUM_STAGES-1:0]  skip_q, skip_d;
  logic                   halt_q, halt_d;
  logic                   done_q, done_d;

  logic                   in_decode;
  logic                   cur_ready;
  logic                   halt_pend;
  logic [NUM_STAGES-1:0]  active;
  logic [IDX_W-1:0]       next_idx;
  logic                   wrap;

  assign in_decode = (idx_q == IDX_W'(DECODE_STAGE));
  assign cur_ready = stage_ready[idx_q];
  assign halt_pend = halt_q | halt_req;

  // Leaving decode, the fresh skip_mask steers the search before it is latched.
  always_comb begin
    active               = in_decode ? ~skip_mask : ~skip_q;
    active[0]            = 1'b1;
    active[DECODE_STAGE] = 1'b1;
  end

  next_stage_finder #(
    .NUM_STAGES(NUM_STAGES),
    .IDX_W     (IDX_W)
  ) u_finder (
    .cur_idx_i (idx_q),
    .active_i  (active),
    .next_idx_o(next_idx),
    .wrap_o    (wrap)
  );

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    retired_d = retired_q;
    wait_d    = wait_q;
    skip_d    = skip_q;
    halt_d    = halt_q;
    done_d    = 1'b0;
    case (state_q)
      RUN: begin
        halt_d = halt_pend;
        if (cur_ready) begin
          wait_d = '0;
          if (wrap) begin
            idx_d     = '0;
            retired_d = retired_q + 1'b1;
            done_d    = 1'b1;
            skip_d    = '0;
            if (halt_pend) state_d = HALTED;
          end else begin
            idx_d = next_idx;
            if (in_decode) skip_d = skip_mask;
          end
        end else if ((MAX_WAIT > 0) && (wait_q == WAIT_W'(MAX_WAIT))) begin
          state_d = FAULT;
          wait_d  = '0;
        end else if (wait_q != {WAIT_W{1'b1}}) begin
          wait_d = wait_q + 1'b1;
        end
      end
      default: wait_d = '0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q   <= RUN;
      idx_q     <= '0;
      retired_q <= '0;
      wait_q    <= '0;
      skip_q    <= '0;
      halt_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      retired_q <= retired_d;
      wait_q    <= wait_d;
      skip_q    <= skip_d;
      halt_q    <= halt_d;
      done_q    <= done_d;
    end
  end

  assign stage       = (state_q == RUN) ? (NUM_STAGES'(1) << idx_q) : '0;
  assign stage_index = (state_q == RUN) ? idx_q : '0;
  assign instr_done  = done_q;
  assign retired     = retired_q;
  assign wait_count  = wait_q;
  assign halted      = (state_q == HALTED);
  assign fault       = (state_q == FAULT);

endmodule

// File: tb/tb_stage_sequencer.sv
// Bench for stage_sequencer: directed vector table, watchdog/no-watchdog
// sequences, and randomized run against a behavioural model.
module tb_stage_sequencer;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  // Instance A: default parameters (MAX_WAIT=15)
  logic       a_rst = 1'b0, a_halt = 1'b0;
  logic [4:0] a_rdy = '0, a_skip = '0;
  logic [4:0] a_stage;
  logic [2:0] a_idx;
  logic       a_done, a_halted, a_fault;
  logic [31:0] a_ret;
  logic [3:0] a_wait;

  stage_sequencer #(.NUM_STAGES(5), .DECODE_STAGE(1), .MAX_WAIT(15), .CNT_W(32)) dut_a (
    .clock(clock), .reset(a_rst), .stage_ready(a_rdy), .skip_mask(a_skip), .halt_req(a_halt),
    .stage(a_stage), .stage_index(a_idx), .instr_done(a_done), .retired(a_ret),
    .wait_count(a_wait), .halted(a_halted), .fault(a_fault));

  // Instance B: MAX_WAIT=4
  logic       b_rst = 1'b0, b_halt = 1'b0;
  logic [4:0] b_rdy = '0, b_skip = '0;
  logic [4:0] b_stage;
  logic [2:0] b_idx;
  logic       b_done, b_halted, b_fault;
  logic [31:0] b_ret;
  logic [2:0] b_wait;

  stage_sequencer #(.NUM_STAGES(5), .DECODE_STAGE(1), .MAX_WAIT(4), .CNT_W(32)) dut_b (
    .clock(clock), .reset(b_rst), .stage_ready(b_rdy), .skip_mask(b_skip), .halt_req(b_halt),
    .stage(b_stage), .stage_index(b_idx), .instr_done(b_done), .retired(b_ret),
    .wait_count(b_wait), .halted(b_halted), .fault(b_fault));

  // Instance C: watchdog disabled
  logic       c_rst = 1'b0, c_halt = 1'b0;
  logic [4:0] c_rdy = '0, c_skip = '0;
  logic [4:0] c_stage;
  logic [2:0] c_idx;
  logic       c_done, c_halted, c_fault;
  logic [31:0] c_ret;
  logic [0:0] c_wait;

  stage_sequencer #(.NUM_STAGES(5), .DECODE_STAGE(1), .MAX_WAIT(0), .CNT_W(32)) dut_c (
    .clock(clock), .reset(c_rst), .stage_ready(c_rdy), .skip_mask(c_skip), .halt_req(c_halt),
    .stage(c_stage), .stage_index(c_idx), .instr_done(c_done), .retired(c_ret),
    .wait_count(c_wait), .halted(c_halted), .fault(c_fault));

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  typedef struct {
    logic        rst;
    logic [4:0]  rdy;
    logic [4:0]  skip;
    logic        halt;
    logic [4:0]  stage;
    logic        done;
    logic [31:0] ret;
    logic [3:0]  wt;
    logic        h;
    logic        f;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst, input logic [4:0] rdy, input logic [4:0] skip,
                     input logic halt, input logic [4:0] stg, input logic done,
                     input int ret, input int wt, input logic h, input logic f);
    vec_t v;
    v.rst = rst; v.rdy = rdy; v.skip = skip; v.halt = halt; v.stage = stg;
    v.done = done; v.ret = ret; v.wt = wt[3:0]; v.h = h; v.f = f;
    vecs.push_back(v);
  endtask

  // Behavioural model of instance A (MAX_WAIT=15, decode at index 1)
  localparam int MW = 15;
  int   m_st;    // 0 running, 1 halted, 2 faulted
  int   m_idx, m_wait;
  logic [31:0] m_ret;
  logic [4:0]  m_skip;
  logic m_hp, m_done;

  function automatic int next_active(input int cur, input logic [4:0] mask);
    for (int j = cur + 1; j < 5; j++)
      if (j == 1 || !mask[j]) return j;
    return -1;
  endfunction

  task automatic model_step(input logic rst, input logic [4:0] rdy, input logic [4:0] skip,
                            input logic halt);
    int n;
    logic hp;
    if (!rst) begin
      m_st = 0; m_idx = 0; m_wait = 0; m_ret = 0; m_skip = 0; m_hp = 0; m_done = 0;
      return;
    end
    m_done = 0;
    if (m_st != 0) begin
      m_wait = 0;
      return;
    end
    hp = m_hp | halt;
    m_hp = hp;
    if (rdy[m_idx]) begin
      n = next_active(m_idx, (m_idx == 1) ? skip : m_skip);
      m_wait = 0;
      if (n < 0) begin
        m_ret++;
        m_done = 1;
        m_skip = 0;
        if (hp) m_st = 1;
        else m_idx = 0;
      end else begin
        if (m_idx == 1) m_skip = skip;
        m_idx = n;
      end
    end else if (m_wait == MW) begin
      m_st = 2;
      m_wait = 0;
    end else begin
      m_wait++;
    end
  endtask

  localparam logic [4:0] ALL = 5'b11111;

  initial begin
    // Directed vectors: inputs applied for one edge, outputs expected after it.
    add(0, ALL, 0, 0, 5'b00001, 0, 0, 0, 0, 0);
    add(1, ALL, 0, 0, 5'b00010, 0, 0, 0, 0, 0);
    add(1, ALL, 0, 0, 5'b00100, 0, 0, 0, 0, 0);
    add(1, ALL, 0, 0, 5'b01000, 0, 0, 0, 0, 0);
    add(1, ALL, 0, 0, 5'b10000, 0, 0, 0, 0, 0);
    add(1, ALL, 0, 0, 5'b00001, 1, 1, 0, 0, 0);
    add(1, ALL, 0, 0, 5'b00010, 0, 1, 0, 0, 0);
    add(1, ALL, 5'b01011, 0, 5'b00100, 0, 1, 0, 0, 0);
    add(1, ALL, 0, 0, 5'b10000, 0, 1, 0, 0, 0);
    add(1, ALL, 0, 0, 5'b00001, 1, 2, 0, 0, 0);
    add(1, ALL, 0, 0, 5'b00010, 0, 2, 0, 0, 0);
    add(1, ALL, 0, 0, 5'b00100, 0, 2, 0, 0, 0);
    add(1, ALL, 5'b11100, 0, 5'b01000, 0, 2, 0, 0, 0);
    add(1, ALL, 0, 0, 5'b10000, 0, 2, 0, 0, 0);
    add(1, ALL, 0, 0, 5'b00001, 1, 3, 0, 0, 0);
    add(1, ALL, 0, 0, 5'b00010, 0, 3, 0, 0, 0);
    add(1, ALL, 0, 0, 5'b00100, 0, 3, 0, 0, 0);
    add(1, 5'b11011, 0, 0, 5'b00100, 0, 3, 1, 0, 0);
    add(1, 5'b11011, 0, 0, 5'b00100, 0, 3, 2, 0, 0);
    add(1, 5'b11011, 0, 0, 5'b00100, 0, 3, 3, 0, 0);
    add(1, ALL, 0, 0, 5'b01000, 0, 3, 0, 0, 0);
    add(1, ALL, 0, 0, 5'b10000, 0, 3, 0, 0, 0);
    add(1, ALL, 0, 0, 5'b00001, 1, 4, 0, 0, 0);
    add(1, ALL, 0, 0, 5'b00010, 0, 4, 0, 0, 0);
    add(1, ALL, 0, 0, 5'b00100, 0, 4, 0, 0, 0);
    add(1, 5'b11011, 0, 1, 5'b00100, 0, 4, 1, 0, 0);
    add(1, ALL, 0, 0, 5'b01000, 0, 4, 0, 0, 0);
    add(1, ALL, 0, 0, 5'b10000, 0, 4, 0, 0, 0);
    add(1, ALL, 0, 0, 5'b00000, 1, 5, 0, 1, 0);
    add(1, ALL, 0, 1, 5'b00000, 0, 5, 0, 1, 0);
    add(0, ALL, 0, 0, 5'b00001, 0, 0, 0, 0, 0);
    add(1, ALL, 0, 0, 5'b00010, 0, 0, 0, 0, 0);
    add(1, ALL, 0, 0, 5'b00100, 0, 0, 0, 0, 0);
    add(1, ALL, 0, 0, 5'b01000, 0, 0, 0, 0, 0);
    add(1, ALL, 0, 0, 5'b10000, 0, 0, 0, 0, 0);
    add(1, ALL, 0, 1, 5'b00000, 1, 1, 0, 1, 0);
    add(0, ALL, 0, 0, 5'b00001, 0, 0, 0, 0, 0);
    add(1, ALL, 0, 0, 5'b00010, 0, 0, 0, 0, 0);
    add(1, ALL, 0, 0, 5'b00100, 0, 0, 0, 0, 0);
    add(1, ALL, 0, 0, 5'b01000, 0, 0, 0, 0, 0);
    add(1, 5'b10111, 0, 0, 5'b01000, 0, 0, 1, 0, 0);
    add(1, 5'b10111, 0, 0, 5'b01000, 0, 0, 2, 0, 0);
    add(0, 5'b10111, 0, 0, 5'b00001, 0, 0, 0, 0, 0);

    foreach (vecs[i]) begin
      a_rst = vecs[i].rst; a_rdy = vecs[i].rdy; a_skip = vecs[i].skip; a_halt = vecs[i].halt;
      tick();
      chk($sformatf("vec%0d stage", i), 64'(a_stage), 64'(vecs[i].stage));
      chk($sformatf("vec%0d instr_done", i), 64'(a_done), 64'(vecs[i].done));
      chk($sformatf("vec%0d retired", i), 64'(a_ret), 64'(vecs[i].ret));
      chk($sformatf("vec%0d wait_count", i), 64'(a_wait), 64'(vecs[i].wt));
      chk($sformatf("vec%0d halted", i), 64'(a_halted), 64'(vecs[i].h));
      chk($sformatf("vec%0d fault", i), 64'(a_fault), 64'(vecs[i].f));
    end

    // Watchdog with MAX_WAIT=4; a pending halt must not override the fault.
    b_rst = 1'b0; b_rdy = ALL; tick();
    b_rst = 1'b1; tick(); tick();
    b_halt = 1'b1; b_rdy = 5'b10111; tick();
    b_halt = 1'b0;
    chk("wd enter stage3", 64'(b_stage), 64'(5'b01000));
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk($sformatf("wd wait %0d", k), 64'(b_wait), 64'(k));
      chk($sformatf("wd no fault %0d", k), 64'(b_fault), 64'd0);
    end
    tick();
    chk("wd fault", 64'(b_fault), 64'd1);
    chk("wd stage zero", 64'(b_stage), 64'd0);
    chk("wd retired", 64'(b_ret), 64'd0);
    chk("wd halted clear", 64'(b_halted), 64'd0);
    chk("wd wait zero", 64'(b_wait), 64'd0);
    b_rdy = ALL;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("wd sticky fault", 64'(b_fault), 64'd1);
      chk("wd sticky stage", 64'(b_stage), 64'd0);
    end
    b_rst = 1'b0; tick();
    chk("wd reset stage", 64'(b_stage), 64'(5'b00001));
    chk("wd reset fault", 64'(b_fault), 64'd0);

    // Watchdog disabled: long stall never faults.
    c_rst = 1'b0; c_rdy = ALL; tick();
    c_rst = 1'b1; tick(); tick();
    c_rdy = 5'b11011;
    for (int k = 0; k < 40; k++) tick();
    chk("nowd fault", 64'(c_fault), 64'd0);
    chk("nowd stage", 64'(c_stage), 64'(5'b00100));
    c_rdy = ALL; tick();
    chk("nowd advance", 64'(c_stage), 64'(5'b01000));

    // Randomized run against the behavioural model.
    a_rst = 1'b0; a_rdy = ALL; a_skip = 0; a_halt = 0;
    model_step(a_rst, a_rdy, a_skip, a_halt);
    tick();
    for (int cyc = 0; cyc < 4000; cyc++) begin
      logic [4:0] exp_stage;
      int exp_idx;
      a_rst  = ($urandom_range(0, 199) != 0);
      a_rdy  = ($urandom_range(0, 19) == 0) ? 5'b00000 : 5'($urandom | $urandom);
      a_skip = 5'($urandom);
      a_halt = ($urandom_range(0, 79) == 0);
      model_step(a_rst, a_rdy, a_skip, a_halt);
      tick();
      exp_stage = (m_st == 0) ? 5'(1 << m_idx) : 5'b0;
      exp_idx   = (m_st == 0) ? m_idx : 0;
      chk("rnd stage", 64'(a_stage), 64'(exp_stage));
      chk("rnd stage_index", 64'(a_idx), 64'(exp_idx));
      chk("rnd instr_done", 64'(a_done), 64'(m_done));
      chk("rnd retired", 64'(a_ret), 64'(m_ret));
      chk("rnd wait_count", 64'(a_wait), 64'(m_wait));
      chk("rnd halted", 64'(a_halted), 64'(m_st == 1));
      chk("rnd fault", 64'(a_fault), 64'(m_st == 2));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
